// File: rtl/rv32i_types.sv
// Shared RV32I out-of-order core types: CDB payload record and requester indices.
package rv32i_types;

    localparam int ROB_IDX_W   = 5;
    localparam int NUM_CDB_REQ = 3;
    localparam int REQ_ALU     = 0;
    localparam int REQ_MUL     = 1;
    localparam int REQ_LSU     = 2;

    typedef struct packed {
        logic [ROB_IDX_W-1:0] rob_idx;
        logic [4:0]           rd_addr;
        logic [31:0]          data;
        logic                 regf_we;
    } cdb_entry_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: first asserted request at or above ptr, wrapping modulo N.
// ptr is assumed to be in 0..N-1; grant is one-hot or zero.
module rr_arbiter #(
    parameter int N     = 3,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [PTR_W-1:0] grant_idx,
    output logic             grant_any
);

    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves one unassigned (no latch).
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        for (int k = 0; k < N; k++) begin
            int               pos;
            logic [PTR_W-1:0] idx;
            pos = int'(ptr) + k;
            if (pos >= N) pos = pos - N;
            idx = PTR_W'(pos);
            if (!grant_any && req[idx]) begin
                grant_any  = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: round-robin selection of one result per cycle, registered broadcast.
// Optional macro CDB_ARB_SKID_EN adds a 1-entry skid buffer per requester (broadcast latency 2).
module cdb_arbiter
    import rv32i_types::*;
#(
    parameter int  NUM_REQ       = NUM_CDB_REQ,
    parameter int  ROB_IDX_WIDTH = ROB_IDX_W,
    localparam int SRC_W         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   flush,
    input  logic [NUM_REQ-1:0]                     req_valid,
    output logic [NUM_REQ-1:0]                     req_ready,
    input  logic [NUM_REQ-1:0][ROB_IDX_WIDTH-1:0]  req_rob_idx,
    input  logic [NUM_REQ-1:0][4:0]                req_rd_addr,
    input  logic [NUM_REQ-1:0][31:0]               req_data,
    input  logic [NUM_REQ-1:0]                     req_regf_we,
    output logic                                   cdb_valid,
    output logic [SRC_W-1:0]                       cdb_src,
    output logic [ROB_IDX_WIDTH-1:0]               cdb_rob_idx,
    output logic [4:0]                             cdb_rd_addr,
    output logic [31:0]                            cdb_data,
    output logic                                   cdb_regf_we,
    output logic [31:0]                            stall_cnt
);

    logic [SRC_W-1:0]   rr_ptr;
    logic [NUM_REQ-1:0] arb_req;
    logic [NUM_REQ-1:0] grant;
    logic [SRC_W-1:0]   grant_idx;
    logic               grant_any;
    logic               take;
    logic               stalled;
    cdb_entry_t         in_entry [NUM_REQ];
    cdb_entry_t         sel_entry;
    cdb_entry_t         cdb_q;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            in_entry[i].rob_idx = ROB_IDX_W'(req_rob_idx[i]);
            in_entry[i].rd_addr = req_rd_addr[i];
            in_entry[i].data    = req_data[i];
            in_entry[i].regf_we = req_regf_we[i];
        end
    end

    rr_arbiter #(
        .N     (NUM_REQ),
        .PTR_W (SRC_W)
    ) u_rr_arbiter (
        .req       (arb_req),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

`ifdef CDB_ARB_SKID_EN
    logic [NUM_REQ-1:0] skid_valid;
    cdb_entry_t         skid_entry [NUM_REQ];

    assign arb_req   = skid_valid & {NUM_REQ{~flush}};
    assign req_ready = (rst && !flush) ? ~skid_valid : '0;
    assign take      = grant_any;
    assign sel_entry = skid_entry[grant_idx];
    assign stalled   = |(skid_valid & ~grant);

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            skid_valid <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant[i]) skid_valid[i] <= 1'b0;
                if (req_valid[i] && req_ready[i]) skid_valid[i] <= 1'b1;
            end
        end
    end

    // NOTE: payload storage is not reset; skid_valid alone decides whether an entry is live.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i] && req_ready[i]) skid_entry[i] <= in_entry[i];
        end
    end
`else
    assign arb_req   = req_valid & {NUM_REQ{~flush}};
    assign req_ready = rst ? grant : '0;
    assign take      = |req_ready;
    assign sel_entry = in_entry[grant_idx];
    assign stalled   = |(req_valid & ~req_ready);
`endif

    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous and active-low, so it is tested inside the clocked block.
        if (!rst) begin
            rr_ptr    <= '0;
            cdb_valid <= 1'b0;
            cdb_src   <= '0;
            cdb_q     <= '0;
            stall_cnt <= '0;
        end else begin
            cdb_valid <= take;
            if (take) begin
                cdb_src       <= grant_idx;
                cdb_q         <= sel_entry;
                // x0 is hardwired to zero, so a write to it must never reach the register file.
                cdb_q.regf_we <= sel_entry.regf_we && (sel_entry.rd_addr != 5'd0);
                rr_ptr        <= (grant_idx == SRC_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
            end
            if (stalled) stall_cnt <= sat_inc(stall_cnt);
        end
    end

    assign cdb_rob_idx = ROB_IDX_WIDTH'(cdb_q.rob_idx);
    assign cdb_rd_addr = cdb_q.rd_addr;
    assign cdb_data    = cdb_q.data;
    assign cdb_regf_we = cdb_q.regf_we;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: directed vectors push expected broadcasts, a monitor pops and compares.
module tb_cdb_arbiter;
    import rv32i_types::*;

    typedef struct {
        int          src;
        logic [4:0]  rob;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        we;
        int          cyc;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic [2:0]       req_valid;
    logic [2:0]       req_ready;
    logic [2:0][4:0]  req_rob_idx;
    logic [2:0][4:0]  req_rd_addr;
    logic [2:0][31:0] req_data;
    logic [2:0]       req_regf_we;
    logic             cdb_valid;
    logic [1:0]       cdb_src;
    logic [4:0]       cdb_rob_idx;
    logic [4:0]       cdb_rd_addr;
    logic [31:0]      cdb_data;
    logic             cdb_regf_we;
    logic [31:0]      stall_cnt;

    // Per-requester payloads and the broadcast regf_we expected for each (mul targets x0).
    logic [4:0]  rob_tab  [3] = '{5'd3, 5'd7, 5'd9};
    logic [4:0]  rd_tab   [3] = '{5'd5, 5'd0, 5'd12};
    logic [31:0] data_tab [3] = '{32'h0000_1234, 32'h0000_BEEF, 32'hCAFE_0001};
    logic        we_tab   [3] = '{1'b1, 1'b1, 1'b0};
    logic        bwe_tab  [3] = '{1'b1, 1'b0, 1'b0};
    int          g_tab    [4] = '{REQ_ALU, REQ_MUL, REQ_LSU, REQ_ALU};

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   exp_stall = 0;
    exp_t exp_q [$];
    exp_t mon_e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cdb_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_rob_idx (req_rob_idx),
        .req_rd_addr (req_rd_addr),
        .req_data    (req_data),
        .req_regf_we (req_regf_we),
        .cdb_valid   (cdb_valid),
        .cdb_src     (cdb_src),
        .cdb_rob_idx (cdb_rob_idx),
        .cdb_rd_addr (cdb_rd_addr),
        .cdb_data    (cdb_data),
        .cdb_regf_we (cdb_regf_we),
        .stall_cnt   (stall_cnt)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic push_exp(input int src, input int lat);
        exp_t e;
        e.src  = src;
        e.rob  = rob_tab[src];
        e.rd   = rd_tab[src];
        e.data = data_tab[src];
        e.we   = bwe_tab[src];
        e.cyc  = cyc + lat;
        exp_q.push_back(e);
    endtask

    // Called at a negedge: drive one cycle, check ready combinationally, then stall_cnt after the edge.
    task automatic step(input logic [2:0] valid, input logic fl, input logic [2:0] ready_exp,
                        input int stall_inc, input string name);
        req_valid = valid;
        flush     = fl;
        #1;
        check({name, " ready"}, 64'(req_ready), 64'(ready_exp));
        @(negedge clk);
        exp_stall += stall_inc;
        check({name, " stall_cnt"}, 64'(stall_cnt), 64'(exp_stall));
    endtask

    always @(negedge clk) begin
        if (cdb_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_bcast: got src %0d data 0x%0h at cycle %0d, required no broadcast",
                         cdb_src, cdb_data, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check("bcast cycle", 64'(cyc), 64'(mon_e.cyc));
                check("bcast src", 64'(cdb_src), 64'(mon_e.src));
                check("bcast rob_idx", 64'(cdb_rob_idx), 64'(mon_e.rob));
                check("bcast rd_addr", 64'(cdb_rd_addr), 64'(mon_e.rd));
                check("bcast data", 64'(cdb_data), 64'(mon_e.data));
                check("bcast regf_we", 64'(cdb_regf_we), 64'(mon_e.we));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000");
        $fatal(1);
    end

    initial begin
        rst       = 1'b0;
        flush     = 1'b0;
        req_valid = '0;
        for (int i = 0; i < 3; i++) begin
            req_rob_idx[i] = rob_tab[i];
            req_rd_addr[i] = rd_tab[i];
            req_data[i]    = data_tab[i];
            req_regf_we[i] = we_tab[i];
        end
        repeat (2) @(negedge clk);

        req_valid = 3'b111;
        #1;
        check("reset ready", 64'(req_ready), 64'(3'b000));
        check("reset cdb_valid", 64'(cdb_valid), 64'(0));
        check("reset cdb_src", 64'(cdb_src), 64'(0));
        check("reset cdb_rob_idx", 64'(cdb_rob_idx), 64'(0));
        check("reset cdb_rd_addr", 64'(cdb_rd_addr), 64'(0));
        check("reset cdb_data", 64'(cdb_data), 64'(0));
        check("reset cdb_regf_we", 64'(cdb_regf_we), 64'(0));
        @(negedge clk);
        check("reset stall_cnt", 64'(stall_cnt), 64'(0));
        rst       = 1'b1;
        exp_stall = 0;

`ifndef CDB_ARB_SKID_EN
        for (int k = 0; k < 4; k++) begin
            push_exp(g_tab[k], 1);
            step(3'b111, 1'b0, 3'(1 << g_tab[k]), 1, "contend");
        end
        push_exp(REQ_MUL, 1);
        step(3'b010, 1'b0, 3'b010, 0, "mul_before_rst");

        rst       = 1'b0;
        req_valid = 3'b111;
        #1;
        check("rst_mid ready", 64'(req_ready), 64'(3'b000));
        @(negedge clk);
        exp_stall = 0;
        check("rst_mid cdb_valid", 64'(cdb_valid), 64'(0));
        check("rst_mid cdb_src", 64'(cdb_src), 64'(0));
        check("rst_mid cdb_data", 64'(cdb_data), 64'(0));
        check("rst_mid stall_cnt", 64'(stall_cnt), 64'(0));
        rst = 1'b1;

        push_exp(REQ_ALU, 1);
        step(3'b111, 1'b0, 3'b001, 1, "post_rst");
        step(3'b000, 1'b0, 3'b000, 0, "idle");
        check("idle cdb_valid", 64'(cdb_valid), 64'(0));
        push_exp(REQ_ALU, 1);
        step(3'b001, 1'b0, 3'b001, 0, "single_alu");
        push_exp(REQ_MUL, 1);
        step(3'b010, 1'b0, 3'b010, 0, "x0_mul");
        step(3'b011, 1'b1, 3'b000, 1, "flush");
        check("flush cdb_valid", 64'(cdb_valid), 64'(0));
        push_exp(REQ_ALU, 1);
        step(3'b011, 1'b0, 3'b001, 1, "after_flush");
        push_exp(REQ_MUL, 1);
        step(3'b011, 1'b0, 3'b010, 1, "rr_mul");
        step(3'b000, 1'b0, 3'b000, 0, "drain");
`else
        push_exp(REQ_ALU, 2);
        push_exp(REQ_MUL, 3);
        step(3'b011, 1'b0, 3'b111, 0, "skid_load");
        step(3'b000, 1'b0, 3'b100, 1, "skid_alu_grant");
        step(3'b000, 1'b0, 3'b101, 0, "skid_mul_grant");
        step(3'b000, 1'b0, 3'b111, 0, "skid_empty");
        step(3'b001, 1'b0, 3'b111, 0, "skid_load_alu");
        step(3'b000, 1'b1, 3'b000, 1, "skid_flush");
        check("skid_flush cdb_valid", 64'(cdb_valid), 64'(0));
        step(3'b000, 1'b0, 3'b111, 0, "skid_after_flush");
        check("skid_after_flush cdb_valid", 64'(cdb_valid), 64'(0));
`endif

        for (int w = 0; w < 5 && exp_q.size() != 0; w++) @(negedge clk);
        check("scoreboard empty", 64'(exp_q.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 3: requester count (0 = alu, 1 = mul, 2 = load/store).
REQ-002 SHALL have parameter ROB_IDX_WIDTH, default 5: ROB index width.
REQ-003 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-low reset (0 = reset).
REQ-005 SHALL have port flush, input, 1: squash all pending and in-flight results.
REQ-006 SHALL have port req_valid, input, NUM_REQ: per-requester result valid.
REQ-007 SHALL have port req_ready, output, NUM_REQ: per-requester accept.
REQ-008 SHALL have port req_rob_idx, input, NUM_REQ x ROB_IDX_WIDTH: producing ROB entry.
REQ-009 SHALL have port req_rd_addr, input, NUM_REQ x 5: architectural destination.
REQ-010 SHALL have port req_data, input, NUM_REQ x 32: result value.
REQ-011 SHALL have port req_regf_we, input, NUM_REQ: result writes the register file.
REQ-012 SHALL have port cdb_valid, output, 1: broadcast valid.
REQ-013 SHALL have port cdb_src, output, clog2(NUM_REQ): index of the winning requester.
REQ-014 SHALL have outputs cdb_rob_idx, cdb_rd_addr, cdb_data, cdb_regf_we: the broadcast payload, widths as the matching inputs.
REQ-015 SHALL have port stall_cnt, output, 32: saturating count of cycles in which a valid request was not accepted.

Function
REQ-016 SHALL accept at most one request per cycle; a transfer occurs when req_valid[i] and req_ready[i] are both 1.
REQ-017 SHALL use round-robin arbitration: grant the lowest index i at or above rr_ptr (wrapping modulo NUM_REQ) with req_valid[i] = 1.
REQ-018 SHALL set rr_ptr to (granted index + 1) mod NUM_REQ after each transfer, and leave it unchanged when there is no transfer.
REQ-019 SHALL drive req_ready one-hot or zero, depending combinationally on req_valid and rr_ptr only.
REQ-020 SHALL register the accepted payload into the cdb_* outputs, with cdb_valid = 1 on the cycle after the transfer (latency 1) and held for exactly one cycle.
REQ-021 SHALL force cdb_regf_we to 0 when the accepted rd_addr is 0.
REQ-022 SHALL, when flush = 1: drive req_ready to all zero, set cdb_valid to 0 the next cycle, and leave rr_ptr unchanged.
REQ-023 SHALL increment stall_cnt each cycle that any req_valid[i] = 1 has req_ready[i] = 0 (including flush cycles), and saturate at 0xFFFFFFFF.
REQ-024 SHALL, with all req_valid = 0, produce cdb_valid = 0 the next cycle.

Reset
REQ-025 SHALL, while rst = 0 at a clock edge, set rr_ptr = 0, cdb_valid = 0, cdb_src = 0, cdb_rob_idx = 0, cdb_rd_addr = 0, cdb_data = 0, cdb_regf_we = 0 and stall_cnt = 0, and clear the skid buffers if present.
REQ-026 SHALL hold req_ready all zero while rst = 0, and discard any in-flight result when reset is asserted mid-operation.

Configuration
REQ-027 SHALL, with macro CDB_ARB_SKID_EN defined, give each requester a 1-entry skid buffer:
- req_ready[i] = buffer i empty;
- arbitration per REQ-017/018 runs over occupied buffers;
- the granted buffer empties on the grant edge and may reload on that same edge;
- latency from transfer to cdb_valid is 2 cycles;
- flush empties all buffers;
- stall_cnt counts cycles in which an occupied buffer is not granted.
REQ-028 SHALL, without CDB_ARB_SKID_EN, behave exactly per REQ-016..024 with no buffering.

Structure
REQ-029 SHALL take the cdb_entry_t payload typedef (rob_idx, rd_addr, data, regf_we) and the requester-index constants from shared package rv32i_types.
REQ-030 SHALL contain one sub-module, rr_arbiter: parameterized round-robin grant logic taking request vector and pointer and producing a one-hot grant.

Verification
REQ-031 SHALL cover single request: only alu valid (rob 3, rd x5, data 0x1234) -> req_ready = 001 in the same cycle; next cycle cdb_valid = 1, src = 0, rob 3, rd 5, data 0x1234.
REQ-032 SHALL cover all contend: all three valid continuously from reset -> grants 0, 1, 2, 0 on consecutive cycles; stall_cnt = 1 per cycle.
REQ-033 SHALL cover the x0 rule: mul result with rd_addr 0 and regf_we 1 -> broadcast cdb_regf_we = 0.
REQ-034 SHALL cover flush: flush with alu and mul valid -> req_ready = 000, cdb_valid = 0 next cycle, rr_ptr unchanged.
REQ-035 SHALL cover reset mid-stream: rst = 0 for one cycle after grant to mul -> all outputs zero and the next grant with all valid goes to alu.
REQ-036 SHALL cover CDB_ARB_SKID_EN: alu and mul load in the same cycle -> alu broadcast 2 cycles later, mul 3 cycles later; req_ready[1] low until the mul buffer drains.
